// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a two's-complement overflow output (ovf).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s_c;
  logic             fa_co_c;

  // Full adder on the current operand LSBs and the running carry
  assign fa_s_c  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_co_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_s_c, res_q[WIDTH-1:1]};
        carry_d = fa_co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // Result becomes visible only once the final bit has been formed
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_s_c, res_q[WIDTH-1:1]};
          cout_d  = fa_co_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co_c;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed table, back-to-back and reset sequences, random
// operands against an arithmetic model (WIDTH=8), and an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result sign bits
  function automatic logic [9:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned t;
    logic        v;
    t = int'(x) + int'(y) + int'(c);
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t[8], t[7:0]};
  endfunction

  // One complete WIDTH=8 operation with timing and hold checks
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] es, input logic ec, input logic ev);
    int         k;
    bit         got, held, busy_ok;
    logic [7:0] prev;
    prev = sum8;
    @(negedge clk);
    start8 = 1'b1; a8 = ia; b8 = ib; cin8 = ic;
    @(posedge clk); #1;
    start8 = 1'b0;
    got = 0; held = 1; busy_ok = 1; k = 0;
    while (!got && k < 40) begin
      if (busy8 !== 1'b1) busy_ok = 0;
      if (sum8 !== prev) held = 0;
      @(posedge clk); #1;
      k++;
      if (done8 === 1'b1) got = 1;
    end
    chk("op8_latency", 32'(k), 32'd8);
    chk("op8_busy_run", 32'(busy_ok), 32'd1);
    chk("op8_sum_held_run", 32'(held), 32'd1);
    chk("op8_sum", 32'(sum8), 32'(es));
    chk("op8_cout", 32'(cout8), 32'(ec));
    chk("op8_busy_at_done", 32'(busy8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("op8_ovf", 32'(ovf8), 32'(ev));
`else
    if (ev === 1'bx) $display("note: unknown ovf expectation");
`endif
    @(posedge clk); #1;
    chk("op8_done_one_cycle", 32'(done8), 32'd0);
    chk("op8_sum_held_idle", 32'(sum8), 32'(es));
  endtask

  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    int         k;
    bit         got;
    logic [4:0] e;
    e = 5'(ia) + 5'(ib) + 5'(ic);
    @(negedge clk);
    start4 = 1'b1; a4 = ia; b4 = ib; cin4 = ic;
    @(posedge clk); #1;
    start4 = 1'b0;
    got = 0; k = 0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (done4 === 1'b1) got = 1;
    end
    chk("op4_latency", 32'(k), 32'd4);
    chk("op4_sum", 32'(sum4), 32'(e[3:0]));
    chk("op4_cout", 32'(cout4), 32'(e[4]));
    @(posedge clk); #1;
    chk("op4_done_one_cycle", 32'(done4), 32'd0);
  endtask

  initial begin
    vec_t       vecs[7];
    logic [9:0] r;
    logic [7:0] ra, rb;
    logic       rc;
    int         dcount;
    bit         no_done;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_sum", 32'(sum8), 32'd0);
    chk("reset_cout", 32'(cout8), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

    // start held through RUN with new operands: ignored, then re-accepted in DONE
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h66;
    dcount = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) dcount++;
      if (k == 8) begin
        chk("b2b_done1", 32'(done8), 32'd1);
        chk("b2b_sum1", 32'(sum8), 32'h46);
      end
      if (k == 9) begin
        chk("b2b_done_drop", 32'(done8), 32'd0);
        chk("b2b_busy_restart", 32'(busy8), 32'd1);
        chk("b2b_sum_held", 32'(sum8), 32'h46);
        start8 = 1'b0;
      end
      if (k == 17) begin
        chk("b2b_done2", 32'(done8), 32'd1);
        chk("b2b_sum2", 32'(sum8), 32'hBB);
        chk("b2b_cout2", 32'(cout8), 32'd0);
      end
    end
    chk("b2b_done_count", 32'(dcount), 32'd2);

    // Reset on the 4th RUN edge abandons the operation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_busy", 32'(busy8), 32'd0);
    chk("rst_run_sum", 32'(sum8), 32'd0);
    chk("rst_run_cout", 32'(cout8), 32'd0);
    chk("rst_run_done", 32'(done8), 32'd0);
    rst = 1'b0;
    no_done = 1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0) no_done = 0;
    end
    chk("rst_run_no_done", 32'(no_done), 32'd1);
    do_op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      r  = ref_add8(ra, rb, rc);
      do_op8(ra, rb, rc, r[7:0], r[8], r[9]);
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          do_op4(4'(x), 4'(y), 1'(c));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
